// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
// Holds the arbiter state encoding and the default line/address widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_e;

    localparam int LINE_WIDTH_DEF = 256;
    localparam int ADDR_WIDTH_DEF = 32;

    typedef logic [LINE_WIDTH_DEF-1:0] line_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] addr_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog: counts cycles spent waiting on memory and raises a
// sticky timeout flag once TIMEOUT_CYCLES is reached (0 disables it).
// Ports: clk, rst_n, busy (transaction open), done (memory completion),
//        timeout (sticky flag, cleared only by reset).
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic done,
    output logic timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam bit EN = (TIMEOUT_CYCLES != 0);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          hit;

    assign cnt_inc = cnt + CW'(1);
    // The cycle that completes the count is the one that trips the flag.
    assign hit = EN && busy && !done && (cnt != LIMIT) && (cnt_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            if (!busy || done) begin
                cnt <= '0;
            end else if (EN && cnt != LIMIT) begin
                cnt <= cnt_inc;
            end
            if (hit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the IMEM and DMEM refill ports.
// Ports: imem_* / dmem_* requester strobe/done ports, mem_* memory port,
//        timeout_o watchdog flag, imem/dmem_grants_o wrapping grant counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int LINE_WIDTH     = LINE_WIDTH_DEF,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_strobe_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic                  imem_done_o,
    output logic [LINE_WIDTH-1:0] imem_data_o,
    input  logic                  dmem_strobe_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_rw_i,
    input  logic [LINE_WIDTH-1:0] dmem_data_i,
    output logic                  dmem_done_o,
    output logic [LINE_WIDTH-1:0] dmem_data_o,
    output logic                  mem_strobe_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rw_o,
    output logic [LINE_WIDTH-1:0] mem_data_o,
    input  logic                  mem_done_i,
    input  logic [LINE_WIDTH-1:0] mem_data_i,
    output logic                  timeout_o,
    output logic [CNT_WIDTH-1:0]  imem_grants_o,
    output logic [CNT_WIDTH-1:0]  dmem_grants_o
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

    arb_state_e    state;
    arb_state_e    state_n;
    logic          grant_i;
    logic          grant_d;
    logic [SW-1:0] streak;
    logic          busy;

    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state)
            IDLE: begin
                // DMEM wins unless it has used up its streak while IMEM waits.
                if (dmem_strobe_i && (!imem_strobe_i || streak < SMAX)) begin
                    state_n = BUSY_D;
                    grant_d = 1'b1;
                end else if (imem_strobe_i) begin
                    state_n = BUSY_I;
                    grant_i = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_done_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_o    <= '0;
            mem_rw_o      <= 1'b0;
            mem_data_o    <= '0;
            streak        <= '0;
            imem_grants_o <= '0;
            dmem_grants_o <= '0;
        end else if (grant_d) begin
            mem_addr_o    <= dmem_addr_i;
            mem_rw_o      <= dmem_rw_i;
            mem_data_o    <= dmem_data_i;
            dmem_grants_o <= dmem_grants_o + CNT_WIDTH'(1);
            if (!imem_strobe_i) begin
                streak <= '0;
            end else if (streak != SMAX) begin
                streak <= streak + SW'(1);
            end
        end else if (grant_i) begin
            mem_addr_o    <= imem_addr_i;
            mem_rw_o      <= 1'b0;
            mem_data_o    <= '0;
            streak        <= '0;
            imem_grants_o <= imem_grants_o + CNT_WIDTH'(1);
        end
    end

    assign busy         = (state != IDLE);
    assign mem_strobe_o = busy;
    assign imem_done_o  = (state == BUSY_I) && mem_done_i;
    assign dmem_done_o  = (state == BUSY_D) && mem_done_i;
    // Read data is only meaningful alongside done; hold zero otherwise.
    assign imem_data_o  = imem_done_o ? mem_data_i : '0;
    assign dmem_data_o  = dmem_done_o ? mem_data_i : '0;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .busy   (busy),
        .done   (mem_done_i),
        .timeout(timeout_o)
    );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, cache-line-wide main-memory port between the core's instruction-fetch (IMEM) and data (DMEM) line-refill requesters.
- Sits between the core's M_IMEM/M_DMEM strobe/done ports and the memory model or controller.
- Grants one requester at a time, latches its command, and routes done/data back to it.
- DMEM has priority; a streak limiter prevents IMEM starvation. A watchdog flags a memory that never completes.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- LINE_WIDTH, 256, cache-line data width.
- MAX_D_STREAK, 4, max consecutive DMEM grants while IMEM is pending (≥1).
- TIMEOUT_CYCLES, 1024, busy cycles before timeout flag; 0 disables.
- CNT_WIDTH, 32, width of the grant counters.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_strobe_i  in  1  IMEM request; held high until imem_done_o.
- imem_addr_i  in  ADDR_WIDTH  IMEM line address.
- imem_done_o  out  1  one-cycle completion pulse to IMEM.
- imem_data_o  out  LINE_WIDTH  read line to IMEM.
- dmem_strobe_i  in  1  DMEM request; held high until dmem_done_o.
- dmem_addr_i  in  ADDR_WIDTH  DMEM line address.
- dmem_rw_i  in  1  1 = write, 0 = read.
- dmem_data_i  in  LINE_WIDTH  DMEM write line.
- dmem_done_o  out  1  one-cycle completion pulse to DMEM.
- dmem_data_o  out  LINE_WIDTH  read line to DMEM.
- mem_strobe_o  out  1  memory request.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_rw_o  out  1  memory write enable.
- mem_data_o  out  LINE_WIDTH  memory write line.
- mem_done_i  in  1  memory completion pulse.
- mem_data_i  in  LINE_WIDTH  memory read line.
- timeout_o  out  1  sticky watchdog flag.
- imem_grants_o  out  CNT_WIDTH  IMEM grant count, wraps.
- dmem_grants_o  out  CNT_WIDTH  DMEM grant count, wraps.

Behaviour:
- **Reset values:** all outputs 0, state IDLE, streak 0, watchdog 0, counters 0.
- **FSM states:** IDLE, BUSY_I, BUSY_D.
- **IDLE grant decision** (at the clock edge):
  - DMEM only → BUSY_D.
  - IMEM only → BUSY_I.
  - Both, with streak < MAX_D_STREAK → BUSY_D.
  - Both, with streak == MAX_D_STREAK → BUSY_I.
  - Neither → stay IDLE.
- **Command latch on grant:** mem_addr_o, mem_rw_o (IMEM grant forces 0), mem_data_o (IMEM grant forces 0) are registered. Later requester input changes are ignored until done.
- **Strobe timing:** mem_strobe_o = 1 in the BUSY states, 0 in IDLE. First strobe cycle is the cycle after the request is seen in IDLE (1-cycle grant latency).
- **Done routing:** BUSY_x with mem_done_i = 1 → x_done_o = 1 combinationally in the same cycle, then → IDLE. The non-granted done is always 0.
- **Data routing:** imem_data_o and dmem_data_o = mem_data_i combinationally. Valid only while the matching done is high.
- **Back-to-back requests:** after done the requester drops its strobe. IDLE re-evaluates the next cycle, so the minimum spacing between memory strobes is one IDLE cycle.
- **Streak counter:**
  - +1 (saturating at MAX_D_STREAK) on a DMEM grant while imem_strobe_i = 1.
  - Cleared on an IMEM grant.
  - Cleared on a DMEM grant while imem_strobe_i = 0.
- **Watchdog:**
  - Counts cycles in BUSY; clears on done and in IDLE.
  - On reaching TIMEOUT_CYCLES: timeout_o ← 1, sticky until reset.
  - The transaction is not aborted; the arbiter keeps waiting.
- **mem_done_i in IDLE:** ignored.
- **Grant counters:** increment on each grant edge, wrapping modulo 2^CNT_WIDTH.
- **Reset mid-transaction:** asynchronous return to IDLE, outputs 0. The memory shares rst_n, so no orphan done is expected; any stray done is ignored per the IDLE rule.

Decomposition:
- **Package mem_arb_pkg:**
  - state enum arb_state_e {IDLE, BUSY_I, BUSY_D}.
  - LINE_WIDTH_DEF = 256, ADDR_WIDTH_DEF = 32.
  - Typedefs line_t, addr_t.
- **One sub-module, mem_arb_watchdog:** busy-cycle counter, TIMEOUT_CYCLES compare, sticky flag. Inputs busy, done; output timeout.

Test Plan:
- IMEM-only read, addr 0x0000_1000; memory returns done after 3 cycles with line 0xA5..A5:
  - mem_strobe_o high in the cycle after request; mem_rw_o = 0.
  - imem_done_o is 1 in the same cycle as mem_done_i; imem_data_o = 0xA5..A5.
  - dmem_done_o stays 0; imem_grants_o = 1.
- DMEM write, addr 0x0000_2000, data 0x1234..; requester changes dmem_addr_i mid-transaction:
  - mem_addr_o stays 0x0000_2000 and mem_rw_o = 1 until done.
- Simultaneous IMEM and DMEM strobes held continuously, MAX_D_STREAK = 4:
  - Grant sequence D, D, D, D, I, D, D, D, D, I.
  - Exactly one IDLE cycle between strobes.
- TIMEOUT_CYCLES = 16, memory never responds:
  - timeout_o rises after 16 busy cycles and stays high after a late done.
  - The late done completes the transaction normally.
- rst_n asserted mid BUSY_D:
  - All outputs 0 immediately (asynchronous).
  - After release, a fresh IMEM request is granted normally.
  - A stray mem_done_i in IDLE produces no done pulse.
